// File: rtl/cmd_tx_wrapper.sv
// UART command transmitter: sends a 16-bit command as two 8N1 frames (high byte first).
// Optional one-entry request holding register enabled by defining CMD_TX_QUEUE_EN.
module cmd_tx_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        TX,
    output logic        busy,
    output logic        cmd_cmplt
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

    state_t      state, state_nxt;
    logic [9:0]  shift, shift_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [11:0] baud_cnt, baud_cnt_nxt;
    logic [7:0]  low_byte;
    logic        busy_nxt, cmplt_nxt;
    logic        baud_end;
    logic        load_word;
    logic [15:0] load_src;
`ifdef CMD_TX_QUEUE_EN
    logic [15:0] hold_word;
    logic        hold_vld, hold_vld_nxt;
    logic        hold_load;
`endif

    // TX is the low bit of the frame shift register, so it is always registered.
    assign TX = shift[0];

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        bit_cnt_nxt  = bit_cnt;
        baud_cnt_nxt = baud_cnt;
        busy_nxt     = busy;
        cmplt_nxt    = cmd_cmplt;
        load_word    = 1'b0;
        load_src     = cmd;
        baud_end     = (baud_cnt == BAUD_LAST);
`ifdef CMD_TX_QUEUE_EN
        hold_vld_nxt = hold_vld;
        hold_load    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (snd_cmd) begin
                    state_nxt = HIGH;
                    load_word = 1'b1;
                    busy_nxt  = 1'b1;
                    cmplt_nxt = 1'b0;
                end
            end
            default: begin
                if (!baud_end) begin
                    baud_cnt_nxt = baud_cnt + 12'd1;
                end else begin
                    baud_cnt_nxt = '0;
                    if (bit_cnt != 4'd9) begin
                        shift_nxt   = {1'b1, shift[9:1]};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else begin
                        bit_cnt_nxt = '0;
                        if (state == HIGH) begin
                            // Low-byte start bit follows the high-byte stop bit with no gap.
                            state_nxt = LOW;
                            shift_nxt = {1'b1, low_byte, 1'b0};
                        end else
`ifdef CMD_TX_QUEUE_EN
                        if (hold_vld) begin
                            state_nxt    = HIGH;
                            load_word    = 1'b1;
                            load_src     = hold_word;
                            hold_vld_nxt = 1'b0;
                        end else if (snd_cmd) begin
                            state_nxt = HIGH;
                            load_word = 1'b1;
                        end else
`endif
                        begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                            cmplt_nxt = 1'b1;
                            shift_nxt = '1;
                        end
                    end
                end
            end
        endcase

        if (load_word) begin
            shift_nxt    = {1'b1, load_src[15:8], 1'b0};
            bit_cnt_nxt  = '0;
            baud_cnt_nxt = '0;
        end

`ifdef CMD_TX_QUEUE_EN
        // A request that arrives while busy parks in the hold slot unless it was chained directly.
        if (state != IDLE && snd_cmd && !hold_vld && !load_word) begin
            hold_load    = 1'b1;
            hold_vld_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '1;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            busy      <= 1'b0;
            cmd_cmplt <= 1'b0;
`ifdef CMD_TX_QUEUE_EN
            hold_vld  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            baud_cnt  <= baud_cnt_nxt;
            busy      <= busy_nxt;
            cmd_cmplt <= cmplt_nxt;
`ifdef CMD_TX_QUEUE_EN
            hold_vld  <= hold_vld_nxt;
`endif
        end
    end

    // Data words carry no reset; they are only read after being loaded.
    always_ff @(posedge clk) begin
        if (load_word) low_byte <= load_src[7:0];
`ifdef CMD_TX_QUEUE_EN
        if (hold_load) hold_word <= cmd;
`endif
    end

endmodule

// File: tb/tb_cmd_tx_wrapper.sv
// Bench for cmd_tx_wrapper (default build): vector table, corner sequences, random run vs line model.
module tb_cmd_tx_wrapper;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        TX, busy, cmd_cmplt;

    int n_cmp = 0;
    int n_bad = 0;

    cmd_tx_wrapper #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd),
        .TX(TX), .busy(busy), .cmd_cmplt(cmd_cmplt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [0:19] bits;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got {TX,busy,cmplt}=%b want %b", name, $time, act, exp);
        end
    endtask

    // Line model: an accepted command becomes 20*B expected line samples.
    logic m_tx = 1'b1;
    logic m_busy = 1'b0;
    logic m_cmplt = 1'b0;
    logic m_q[$];
    bit   chk_en = 1'b0;

    function automatic void push_cmd(input logic [15:0] w);
        logic [7:0] b;
        logic [9:0] fr;
        for (int f = 0; f < 2; f++) begin
            b  = (f == 0) ? w[15:8] : w[7:0];
            fr = {1'b1, b, 1'b0};
            for (int k = 0; k < 10; k++)
                for (int r = 0; r < B; r++) m_q.push_back(fr[k]);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_busy  = 1'b0;
            m_cmplt = 1'b0;
            m_tx    = 1'b1;
        end else if (!m_busy) begin
            if (snd_cmd) begin
                push_cmd(cmd);
                m_tx    = m_q.pop_front();
                m_busy  = 1'b1;
                m_cmplt = 1'b0;
            end
        end else if (m_q.size() > 0) begin
            m_tx = m_q.pop_front();
        end else begin
            m_busy  = 1'b0;
            m_cmplt = 1'b1;
            m_tx    = 1'b1;
        end
    end

    always @(negedge clk)
        if (chk_en) check("model", {TX, busy, cmd_cmplt}, {m_tx, m_busy, m_cmplt});

    // Called at a negedge with the DUT idle; optionally pokes a request mid-command.
    task automatic run_cmd(input logic [15:0] w, input logic [0:19] bits,
                           input int inject, input logic [15:0] other);
        cmd = w;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
        for (int c = 0; c < 20 * B; c++) begin
            if (c % B == 1) check("tx_bit", {2'b00, TX}, {2'b00, bits[c / B]});
            if (c == 20 * B - 1) check("busy_last", {1'b0, busy, cmd_cmplt}, 3'b010);
            snd_cmd = (c == inject);
            if (c == inject) cmd = other;
            @(negedge clk);
        end
        snd_cmd = 1'b0;
        check("done", {TX, busy, cmd_cmplt}, 3'b101);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{word: 16'hA5C3, bits: 20'b0101001011_0110000111};
        vecs[1] = '{word: 16'h1234, bits: 20'b0010010001_0001011001};
        vecs[2] = '{word: 16'h0000, bits: 20'b0000000001_0000000001};
        vecs[3] = '{word: 16'hFFFF, bits: 20'b0111111111_0111111111};
        vecs[4] = '{word: 16'h8001, bits: 20'b0000000011_0100000001};

        // Reset held for 3 edges with a request pending.
        cmd = 16'hA5C3;
        snd_cmd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset", {TX, busy, cmd_cmplt}, 3'b100);
        rst = 1'b0;
        snd_cmd = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_idle", {TX, busy, cmd_cmplt}, 3'b100);

        // Vector table; the first entry also carries an ignored request at cycle 30.
        for (int i = 0; i < 5; i++)
            run_cmd(vecs[i].word, vecs[i].bits, (i == 0) ? 30 : -1, 16'h1234);

        // Reset during bit 5 of the low byte.
        cmd = 16'h5A3C;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (65) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {TX, busy, cmd_cmplt}, 3'b100);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_after", {TX, busy, cmd_cmplt}, 3'b100);
        run_cmd(vecs[0].word, vecs[0].bits, -1, 16'h0000);

        // Back-to-back with snd_cmd held as a level.
        cmd = 16'hA5C3;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (70) @(negedge clk);
        cmd = 16'h1234;
        snd_cmd = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b_done", {TX, busy, cmd_cmplt}, 3'b101);
        @(negedge clk);
        check("b2b_start", {TX, busy, cmd_cmplt}, 3'b010);
        snd_cmd = 1'b0;
        repeat (20 * B + 2) @(negedge clk);
        check("b2b_end", {TX, busy, cmd_cmplt}, 3'b101);

        // Random requests, data and occasional resets against the line model.
        for (int c = 0; c < 3000; c++) begin
            cmd     = 16'($urandom);
            snd_cmd = ($urandom_range(0, 29) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        snd_cmd = 1'b0;
        repeat (100) @(negedge clk);
        check("final_idle", {TX, busy, 1'b0}, 3'b100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
